// File: rtl/alu_writeback_stage.sv
// ALU writeback stage: 2-entry skid buffer toward the register-file write port,
// architectural NZCV flag register and ARM condition evaluation.
// Optional macro ALU_WB_FLAG_FWD_EN: cond_pass sees the flags being written this cycle.
module alu_writeback_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_result,
  input  logic                  in_zero,
  input  logic                  in_carry,
  input  logic                  in_overflow,
  input  logic                  in_negative,
  input  logic                  in_set_flags,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_wr_en,
  input  logic                  flag_load,
  input  logic [3:0]            flag_load_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_wr_en,
  output logic [3:0]            nzcv,
  input  logic [3:0]            cond_code,
  output logic                  cond_pass
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] result;
    logic [REG_ADDR_W-1:0] rd;
    logic                  wr_en;
  } wb_entry_t;

  // Encoded as {head_valid, skid_valid}
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    HEAD  = 2'b10,
    FULL  = 2'b11
  } state_t;

  state_t    state;
  wb_entry_t head, skid, new_entry;
  logic      accept;
  logic [3:0] new_flags, eval_flags;

  assign new_entry  = '{result: in_result, rd: in_rd, wr_en: in_wr_en};
  assign new_flags  = {in_negative, in_zero, in_carry, in_overflow};
  assign in_ready   = (state != FULL);
  assign accept     = in_valid & in_ready;
  assign out_valid  = (state != EMPTY);
  assign out_result = head.result;
  assign out_rd     = head.rd;
  assign out_wr_en  = head.wr_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      head  <= '0;
      skid  <= '0;
      nzcv  <= 4'b0000;
    end else begin
      case (state)
        EMPTY: if (accept) begin
          head  <= new_entry;
          state <= HEAD;
        end
        HEAD: begin
          if (accept) begin
            if (out_ready) head <= new_entry;
            else begin
              skid  <= new_entry;
              state <= FULL;
            end
          end else if (out_ready) begin
            state <= EMPTY;
          end
        end
        FULL: if (out_ready) begin
          head  <= skid;
          state <= HEAD;
        end
        default: state <= EMPTY;
      endcase

      // Flags commit at acceptance, independent of the output stall
      if (flag_load)                  nzcv <= flag_load_data;
      else if (accept && in_set_flags) nzcv <= new_flags;
    end
  end

`ifdef ALU_WB_FLAG_FWD_EN
  always_comb begin
    eval_flags = nzcv;
    if (!rst) begin
      if (flag_load)                   eval_flags = flag_load_data;
      else if (accept && in_set_flags) eval_flags = new_flags;
    end
  end
`else
  assign eval_flags = nzcv;
`endif

  function automatic logic cond_eval(input logic [3:0] cc, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cc)
      4'h0:    return z;
      4'h1:    return !z;
      4'h2:    return c;
      4'h3:    return !c;
      4'h4:    return n;
      4'h5:    return !n;
      4'h6:    return v;
      4'h7:    return !v;
      4'h8:    return c & !z;
      4'h9:    return !c | z;
      4'hA:    return n == v;
      4'hB:    return n != v;
      4'hC:    return !z & (n == v);
      4'hD:    return z | (n != v);
      4'hE:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  assign cond_pass = cond_eval(cond_code, eval_flags);

endmodule

// File: doc/alu_writeback_stage.md
Name: alu_writeback_stage

Overview:
- Pipeline stage directly downstream of the ALU.
- Registers the ALU result, destination register and write enable into a 2-entry skid buffer with a valid/ready handshake toward the register-file write port.
- Owns the architectural NZCV flag register, updated from the ALU flag outputs.
- Evaluates the ARM condition field of the next instruction against the current flags.

Parameters:
- DATA_WIDTH, 32, width of result path.
- REG_ADDR_W, 4, width of destination register index (r0-r15).

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  ALU output valid
- in_ready  output  1  stage can accept; equals NOT skid_valid
- in_result  input  DATA_WIDTH  ALU result
- in_zero, in_carry, in_overflow, in_negative  input  1 each  ALU flags
- in_set_flags  input  1  instruction has S bit; commit flags on accept
- in_rd  input  REG_ADDR_W  destination register
- in_wr_en  input  1  instruction writes rd (0 for CMP-type)
- flag_load  input  1  MSR-style direct flag write
- flag_load_data  input  4  {N,Z,C,V} for flag_load
- out_valid  output  1  head entry valid
- out_ready  input  1  register file accepts
- out_result  output  DATA_WIDTH  head result
- out_rd  output  REG_ADDR_W  head destination
- out_wr_en  output  1  head write enable
- nzcv  output  4  flag register {N,Z,C,V}
- cond_code  input  4  condition field of next instruction
- cond_pass  output  1  condition satisfied (combinational from nzcv)

Behaviour:
- Reset: out_valid=0, out_result=0, out_rd=0, out_wr_en=0, nzcv=0000, skid_valid=0 (in_ready=1 the cycle after reset). Inputs presented while rst=1 are ignored: no accept, no flag update.
- Accept = in_valid AND in_ready.
- Storage: head register (outputs) plus one skid register.
- States, encoded as {head_valid, skid_valid}:
  - EMPTY 00: accept -> HEAD, data in head.
  - HEAD 10, no accept: out_ready -> EMPTY, else hold.
  - HEAD 10, accept: out_ready -> HEAD with head replaced by new data; no out_ready -> FULL with new data in skid.
  - FULL 11: in_ready=0; out_ready -> HEAD with skid moved to head.
- Latency: 1 cycle from accept to out_valid when empty. Head data stays stable while out_valid=1 and out_ready=0. Strict in-order delivery; never drop or duplicate.
- Flags:
  - On accept with in_set_flags=1, nzcv <= {in_negative, in_zero, in_carry, in_overflow} at that edge, regardless of output stall. Flags commit at acceptance, not at drain.
  - flag_load=1: nzcv <= flag_load_data. Has priority over a simultaneous set_flags accept; the data part of that accept still proceeds.
  - Otherwise nzcv holds.
- cond_pass mapping (ARMv4):
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C
  - 4 MI N; 5 PL !N; 6 VS V; 7 VC !V
  - 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V
  - C GT !Z&(N==V); D LE Z|(N!=V); E AL 1; F NV 0
- in_wr_en=0 entries still flow through the buffer with out_wr_en=0.
- rst mid-transfer: both entries discarded, nzcv cleared, next cycle behaves as EMPTY.

Optional Feature:
- Macro: ALU_WB_FLAG_FWD_EN.
- Defined: cond_pass evaluates the flags being written this cycle (flag_load_data if flag_load, else in_* flags if accept with in_set_flags, else nzcv). This removes the 1-cycle flag hazard.
- Undefined: cond_pass uses registered nzcv only.
- nzcv register behaviour is identical in both cases.

Test Plan:
- Reset, then in_valid=1, result=0x0000_0005, rd=3, wr_en=1, out_ready=1 -> next cycle out_valid=1, out_result=5, out_rd=3; following cycle out_valid=0.
- out_ready=0, push A=0x11 then B=0x22 on consecutive cycles -> in_ready=0 after B, out_result holds 0x11; raise out_ready -> 0x11 then 0x22 on consecutive cycles, in_ready returns 1.
- Accept with set_flags=1, N=1, Z=0, C=1, V=0 -> nzcv=1010; cond_code=B (LT) -> cond_pass=1; cond_code=A (GE) -> 0; cond_code=8 (HI) -> 1.
- Same-cycle flag_load=1 (data 0100) and accept with set_flags=1 (flags 1001) -> nzcv=0100, data entry still delivered.
- cond_code=F -> cond_pass=0, cond_code=E -> 1 for all 16 nzcv values.
- With FULL buffer and nzcv=1111, assert rst one cycle -> out_valid=0, nzcv=0000, in_ready=1 next cycle; with ALU_WB_FLAG_FWD_EN, an accept with set_flags, Z=1 and cond_code=0 gives cond_pass=1 in the same cycle.
